// File: rtl/k2_prog_loader.sv
// k2_prog_loader: receives a LEN/payload/CSUM byte frame, writes the payload
// into the K2 program memory and releases the core once the checksum matches.
module k2_prog_loader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [DATA_W-1:0] pm_wdata,
   output logic              core_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   // N-1 is stored so that a full DEPTH-entry frame fits the address width.
   logic [ADDR_W-1:0] lenm1_q, lenm1_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] csum_q, csum_d;
   logic              pm_we_q, pm_we_d;
   logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
   logic [DATA_W-1:0] pm_wdata_q, pm_wdata_d;
   logic              in_ready_q, in_ready_d;
   logic              core_reset_q, core_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              acc;

   // Next state, frame bookkeeping, and registered outputs decoded from next state.
   always_comb begin
      state_d    = state_q;
      lenm1_d    = lenm1_q;
      addr_d     = addr_q;
      csum_d     = csum_q;
      pm_we_d    = 1'b0;
      pm_addr_d  = pm_addr_q;
      pm_wdata_d = pm_wdata_q;
      acc        = in_valid && in_ready_q;

      if (start) begin
         // start always wins; any byte offered this cycle is dropped
         state_d = S_LEN;
         addr_d  = '0;
         csum_d  = '0;
      end else begin
         case (state_q)
            S_LEN: begin
               if (acc) begin
                  if (in_data == '0 || in_data > DATA_W'(DEPTH)) begin
                     state_d = S_ERR;
                  end else begin
                     lenm1_d = ADDR_W'(in_data - DATA_W'(1));
                     csum_d  = in_data;
                     addr_d  = '0;
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (acc) begin
                  pm_we_d    = 1'b1;
                  pm_addr_d  = addr_q;
                  pm_wdata_d = in_data;
                  csum_d     = csum_q ^ in_data;
                  addr_d     = addr_q + ADDR_W'(1);
                  if (addr_q == lenm1_q) state_d = S_CSUM;
               end
            end
            S_CSUM: begin
               if (acc) state_d = (in_data == csum_q) ? S_RUN : S_ERR;
            end
            S_IDLE, S_RUN, S_ERR: state_d = state_q;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d       = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      in_ready_d   = busy_d;
      core_reset_d = (state_d == S_RUN);
      done_d       = (state_d == S_RUN);
      error_d      = (state_d == S_ERR);
   end

   // State and output registers; reset drops everything to idle immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         lenm1_q      <= '0;
         addr_q       <= '0;
         csum_q       <= '0;
         pm_we_q      <= 1'b0;
         pm_addr_q    <= '0;
         pm_wdata_q   <= '0;
         in_ready_q   <= 1'b0;
         core_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lenm1_q      <= lenm1_d;
         addr_q       <= addr_d;
         csum_q       <= csum_d;
         pm_we_q      <= pm_we_d;
         pm_addr_q    <= pm_addr_d;
         pm_wdata_q   <= pm_wdata_d;
         in_ready_q   <= in_ready_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign pm_we      = pm_we_q;
   assign pm_addr    = pm_addr_q;
   assign pm_wdata   = pm_wdata_q;
   assign core_reset = core_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: doc/k2_prog_loader.md
# k2_prog_loader

Program loader for the K2 processor core. It accepts a framed byte stream over a valid/ready handshake and writes the payload into the core's 16-entry, 8-bit instruction memory. While loading, it holds the core in reset. After a verified load it releases the core so execution starts from address 0. It sits between the byte source (UART receiver or host bench) and the core's `reset` input and program-memory write port.

## Interface

Parameters:

- `DATA_W`, default 8: instruction/byte width.
- `ADDR_W`, default 4: program-memory address width.
- `DEPTH`, default 16: number of program-memory entries; maximum legal frame length.

Ports:

- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that begins (or restarts) a load.
- `in_data`, in, DATA_W: stream byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts a byte this cycle.
- `pm_we`, out, 1: program-memory write strobe.
- `pm_addr`, out, ADDR_W: program-memory write address.
- `pm_wdata`, out, DATA_W: program-memory write data.
- `core_reset`, out, 1: active-low reset to the K2 core.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: last load verified; core running.
- `error`, out, 1: last load rejected.

## Operation

- Frame format: LEN byte (N, legal range 1..DEPTH), then N instruction bytes, then a CSUM byte.
  - CSUM must equal the XOR of LEN and all N instruction bytes.
- A transfer takes place on any cycle with `in_valid && in_ready`.
- States:
  - **IDLE**: reset state. `core_reset`=0, `in_ready`=0. `start` moves to LEN.
  - **LEN**: `in_ready`=1.
    - Accepted byte 0 or greater than DEPTH: go to ERR.
    - Otherwise: store N, set running XOR to LEN, clear the address counter, go to DATA.
  - **DATA**: `in_ready`=1. Each accepted byte:
    - issues one write at the current address;
    - XORs the byte into the running checksum;
    - increments the address.
    - After the Nth byte, go to CSUM.
  - **CSUM**: `in_ready`=1. On the accepted byte:
    - match: go to RUN;
    - mismatch: go to ERR.
  - **RUN**: `core_reset`=1, `done`=1. `start` goes to LEN and reasserts `core_reset`=0.
  - **ERR**: `error`=1, `core_reset`=0. `start` goes to LEN.
- `start` in LEN, DATA or CSUM aborts the current frame and restarts at LEN.
  - The address counter and checksum clear.
  - Entries already written stay in memory.
- `core_reset` is 0 in every state except RUN.
- `busy` = state is LEN, DATA or CSUM.
- `done` and `error` are mutually exclusive. Both are cleared on leaving RUN/ERR.
- Entries at addresses N..DEPTH-1 are not written; they keep their previous contents.

## Timing

- Reset values: state=IDLE, `in_ready`=0, `pm_we`=0, `pm_addr`=0, `pm_wdata`=0, `core_reset`=0, `busy`=0, `done`=0, `error`=0, counters=0.
- Reset takes effect asynchronously. Mid-load it aborts immediately to IDLE with all outputs at their reset values; nothing resumes.
- `in_ready` is a registered function of state. It drops in the cycle after the last CSUM byte is accepted.
- Write latency is 1 cycle. A byte accepted at edge k produces `pm_we`=1 with `pm_addr`/`pm_wdata` valid during cycle k+1, for one cycle only.
- Back-to-back bytes give back-to-back write strobes at consecutive addresses.
- `core_reset` rises, and `done` (or `error`) asserts, in the cycle after CSUM is accepted.
- Minimum frame of N bytes: N+2 accepted cycles. `core_reset` goes high 1 cycle after the final accept.
- `start` in RUN: `core_reset` falls in the next cycle.
- Simultaneous `start` and an accepted byte: `start` wins and the byte is discarded.
- The address counter is ADDR_W bits wide. N=DEPTH writes addresses 0..15 with no wrap and no extra write.

## Test plan

- **Reset:** hold `reset`=0 for 8 ns, release, wait 5 cycles -> `core_reset`=0, `in_ready`=0, all flags 0.
- **Good frame:** `start`, then 03, A1, B2, C3, CSUM=03^A1^B2^C3=D3 -> writes (0,A1), (1,B2), (2,C3) on 3 consecutive cycles; `done`=1 and `core_reset`=1 one cycle after D3 is accepted.
- **Bad checksum:** same frame with CSUM=00 -> 3 writes occur, then `error`=1 and `core_reset` stays 0.
- **Length bounds:**
  - LEN=00 -> ERR, no writes.
  - LEN=11 -> ERR, no writes.
  - LEN=10 with 16 bytes 00..0F and CSUM = 10 ^ (00^…^0F) = 10 -> writes addresses 0..15, `done`=1.
- **Backpressure:** `in_valid` toggled 1,0,1,0 during a 2-byte frame -> only handshake cycles advance; writes land at addresses 0 and 1.
- **Abort:**
  - `start` after 2 of 4 data bytes -> back in LEN; a new 1-byte frame loads correctly.
  - `reset` low mid-DATA -> all outputs return to reset values immediately.
